on_weight_store: RTL and testbench
==================================

# on_weight_store

Register bank for the hidden-to-output weights of the output neuron. It sits between the backprop stage and the output neuron: it consumes signed weight deltas from backprop and drives the packed weight bus the output neuron multiplies with. It replaces the hard-wired constant weights. Weights can also be preloaded serially in 4-bit nibbles from the dedicated input pins before training.

## Interface
Parameters:
- `N_W`, default 2: number of hidden-to-output weights.
- `W_BITS`, default 8: weight width, signed two's complement.
- `INIT_W0`, default 1: reset value of weight 0.
- `INIT_W1`, default 2: reset value of weight 1.

Ports:
- `clk_i` input 1: single clock; all state changes on the rising edge.
- `rst_i` input 1: reset, synchronous, active-low.
- `freeze_i` input 1: forward pass in progress (f0/f1 pass); blocks updates.
- `load_en_i` input 1: serial preload strobe; one nibble is taken per cycle while high.
- `load_nib_i` input 4: preload nibble. Order is weight 0 low, weight 0 high, weight 1 low, weight 1 high.
- `upd_valid_i` input 1: backprop offers an update.
- `upd_idx_i` input 1: index of the weight to update.
- `upd_delta_i` input 8: signed delta to subtract.
- `upd_ready_o` output 1: an update is accepted this cycle when valid and ready are both high.
- `upd_ack_o` output 1: one-cycle pulse, the cycle after acceptance.
- `load_done_o` output 1: one-cycle pulse when a preload commits.
- `weights_o` output N_W*W_BITS: packed committed weights, weight 0 in [7:0].
- `round_cnt_o` output 8: number of completed update rounds.
- `err_o` output 1: sticky error flag.

## Operation
- States:
  - IDLE: default state.
  - LOAD: collecting nibbles.
  - COMMIT: copies staging to live for one cycle.
- IDLE → LOAD when `load_en_i`=1. The nibble on that same cycle is captured as nibble 0.
- LOAD:
  - Each cycle with `load_en_i`=1 writes `load_nib_i` into the staging register at nibble pointer p, then p increments.
  - When p reaches 2*N_W−1 and that nibble is captured, go to COMMIT.
  - If `load_en_i`=0 in LOAD: abort to IDLE, discard staging, set `err_o`. Live weights are unchanged.
- COMMIT: live weights ← staging; pulse `load_done_o`; go to IDLE.
- Update acceptance:
  - `upd_ready_o` = (state==IDLE) & !`freeze_i` & !`load_en_i`.
  - When both ready and valid are high, w[idx] ← sat(w[idx] − delta).
- Arithmetic: the subtraction is done at 9-bit signed width, then saturated to [−128, +127].
- Index out of range (idx ≥ N_W): the update is accepted, no weight changes, `err_o` is set, and `upd_ack_o` still pulses.
- `round_cnt_o` increments on every accepted update with idx==N_W−1. It wraps 255→0.
- `err_o` is sticky until reset.
- Simultaneous events:
  - `load_en_i` and `upd_valid_i` in IDLE: load wins; the update is not accepted (ready is low).
  - `freeze_i` rising while an update is valid: not accepted; backprop holds its request.
- Reset values:
  - state IDLE, p=0.
  - `weights_o` = {INIT_W1, INIT_W0}.
  - Staging register = 0.
  - `upd_ready_o` is combinational from the reset state, so it is 1 unless `freeze_i` or `load_en_i` is high.
  - `upd_ack_o`=0, `load_done_o`=0, `round_cnt_o`=0, `err_o`=0.
- Reset mid-load or mid-update overrides everything: the bank returns to the reset values on that edge.

## Timing
- Update latency: `weights_o` shows the new value one cycle after the accept edge. `upd_ack_o` is high in that same cycle.
- Throughput: one update per cycle; back-to-back updates to the same index chain correctly.
- Preload: 2*N_W nibble cycles, plus 1 COMMIT cycle. `weights_o` changes and `load_done_o` is high one cycle after the final nibble edge.
- `weights_o` is registered and stays stable while `freeze_i`=1.

## Structure
- Shared package holds:
  - state enum {IDLE, LOAD, COMMIT};
  - `W_BITS`, `N_W`;
  - `W_MAX` = 127 and `W_MIN` = −128;
  - a function `sat_sub(w, d)`, reused by the output backprop stage.
- One sub-module, `sat_subtractor`: 8-bit signed subtract with saturation (combinational), instantiated once and muxed by index.

## Test plan
- Reset, then check outputs: `weights_o`=16'h0201, `round_cnt_o`=0, `err_o`=0, `upd_ready_o`=1.
- Update idx 0 with delta 8'hFD (−3): weight 0 becomes 4, `upd_ack_o` pulses once. Then update idx 1 with delta 5: weight 1 becomes 8'hFD, `round_cnt_o`=1.
- Saturation:
  - Preload w0=8'h7E, then update with delta −5: w0=8'h7F.
  - Preload w0=8'h81, then update with delta +10: w0=8'h80.
- Preload nibbles 5,A,3,C over 4 cycles: `load_done_o` pulses on cycle 5 and `weights_o`=16'hC3A5. Then drop `load_en_i` after 2 nibbles in a new load: weights stay 16'hC3A5 and `err_o`=1.
- Hold `upd_valid_i` high with `freeze_i`=1 for 3 cycles, then release: no change while frozen; exactly one update is applied on the first cycle after release.
- Assert reset during LOAD after 3 nibbles: next cycle `weights_o`=16'h0201 and the state is IDLE. Then perform 256 round-completing updates: `round_cnt_o` wraps to 0.

Source files
------------

// File: rtl/on_weight_store_pkg.sv
// Shared definitions for the output-neuron weight bank: sizes, saturation
// limits, FSM state codes and the saturating subtract used by backprop.
package on_weight_store_pkg;

  localparam int W_BITS   = 8;
  localparam int N_W      = 2;
  localparam int NIB_BITS = 4;

  localparam logic signed [7:0] W_MAX = 8'sh7F;  // +127
  localparam logic signed [7:0] W_MIN = 8'sh80;  // -128

  // FSM state codes (legacy-compatible constants rather than an enum type)
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  // w - d computed at 9-bit signed width, then clamped to [-128, +127].
  // The output backprop stage uses the same function so both sides agree
  // on rounding of out-of-range results.
  function automatic logic signed [7:0] sat_sub(input logic signed [7:0] w,
                                                input logic signed [7:0] d);
    logic signed [8:0] diff;
    diff = $signed({w[7], w}) - $signed({d[7], d});
    if (diff > 9'sd127) begin
      return W_MAX;
    end else if (diff < -9'sd128) begin
      return W_MIN;
    end else begin
      return diff[7:0];
    end
  endfunction

endpackage

// File: rtl/on_weight_store_sat_subtractor.sv
// Combinational 8-bit signed subtract with saturation. One instance serves
// the whole bank; the top muxes the selected weight into it.
module sat_subtractor (
  input  logic signed [7:0] w,
  input  logic signed [7:0] d,
  output logic signed [7:0] y,
  output logic              clipped
);
  import on_weight_store_pkg::sat_sub;

  logic signed [8:0] raw;

  // Raw 9-bit difference only feeds the clip indicator.
  always_comb begin
    raw     = $signed({w[7], w}) - $signed({d[7], d});
    y       = sat_sub(w, d);
    clipped = (raw[8] != raw[7]);
  end

endmodule

// File: rtl/on_weight_store.sv
// Register bank for the hidden-to-output weights of the output neuron.
// Backprop subtracts signed deltas through a valid/ready port; before
// training the bank can be preloaded serially, one 4-bit nibble per cycle.
//
// Handshake: an update transfers on a rising edge where upd_valid_i and
// upd_ready_o are both high. Ready is low outside IDLE, while frozen, and
// while a preload strobe is present (load wins). Backprop must hold its
// request stable until it transfers; upd_ack_o pulses the cycle after.
module on_weight_store #(
  parameter int                N_W     = 2,
  parameter int                W_BITS  = 8,
  parameter logic [W_BITS-1:0] INIT_W0 = 1,
  parameter logic [W_BITS-1:0] INIT_W1 = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    freeze_i,
  input  logic                    load_en_i,
  input  logic [3:0]              load_nib_i,
  input  logic                    upd_valid_i,
  input  logic                    upd_idx_i,
  input  logic [7:0]              upd_delta_i,
  output logic                    upd_ready_o,
  output logic                    upd_ack_o,
  output logic                    load_done_o,
  output logic [N_W*W_BITS-1:0]   weights_o,
  output logic [7:0]              round_cnt_o,
  output logic                    err_o,
  output logic [1:0]              state_o
);
  import on_weight_store_pkg::IDLE;
  import on_weight_store_pkg::LOAD;
  import on_weight_store_pkg::COMMIT;
  import on_weight_store_pkg::NIB_BITS;

  localparam int                NIBS   = 2 * N_W;
  localparam int                P_BITS = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [P_BITS-1:0] P_LAST = P_BITS'(NIBS - 1);

  // Reset value of weight i; weights beyond the two configured ones clear.
  function automatic logic [W_BITS-1:0] init_val(input int i);
    if (i == 0)      return INIT_W0;
    else if (i == 1) return INIT_W1;
    else             return '0;
  endfunction

  logic [1:0]              state;
  logic [P_BITS-1:0]       ptr;
  logic [N_W*W_BITS-1:0]   staging;
  logic [N_W*W_BITS-1:0]   staging_next;
  logic [W_BITS-1:0]       w_q [N_W];
  logic                    ack;
  logic                    done;
  logic                    err;
  logic [7:0]              round_cnt;

  logic                    idx_ok;
  logic                    last_idx;
  logic                    accept;
  logic signed [7:0]       sel_w;
  logic signed [7:0]       new_w;
  logic                    clipped;

  // Staging image with the current nibble merged in at the load pointer.
  always_comb begin
    staging_next = staging;
    staging_next[ptr*NIB_BITS +: NIB_BITS] = load_nib_i;
  end

  // Handshake decode and selection of the weight being updated.
  always_comb begin
    idx_ok      = ({31'd0, upd_idx_i} < 32'(N_W));
    last_idx    = ({31'd0, upd_idx_i} == 32'(N_W - 1));
    upd_ready_o = (state == IDLE) && !freeze_i && !load_en_i;
    accept      = upd_valid_i && upd_ready_o;
    sel_w       = idx_ok ? $signed(w_q[upd_idx_i]) : 8'sd0;
  end

  sat_subtractor u_sat (
    .w       (sel_w),
    .d       ($signed(upd_delta_i)),
    .y       (new_w),
    .clipped (clipped)
  );

  // Preload FSM, weight updates, round counter and sticky error.
  // The live copy is written on the edge that takes the final nibble, so
  // during the COMMIT cycle weights_o already shows the preloaded values
  // and load_done_o is high alongside it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      ptr       <= '0;
      staging   <= '0;
      ack       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      round_cnt <= 8'd0;
      for (int i = 0; i < N_W; i++) begin
        w_q[i] <= init_val(i);
      end
    end else begin
      ack  <= accept;
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (load_en_i) begin
            staging <= staging_next;
            ptr     <= ptr + 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (load_en_i) begin
            staging <= staging_next;
            if (ptr == P_LAST) begin
              for (int i = 0; i < N_W; i++) begin
                w_q[i] <= staging_next[i*W_BITS +: W_BITS];
              end
              done  <= 1'b1;
              ptr   <= '0;
              state <= COMMIT;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end else begin
            // Strobe dropped mid-load: throw the partial image away.
            staging <= '0;
            ptr     <= '0;
            err     <= 1'b1;
            state   <= IDLE;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Accept only happens in IDLE, so it never collides with a commit.
      if (accept) begin
        if (idx_ok) begin
          w_q[upd_idx_i] <= new_w;
        end else begin
          err <= 1'b1;
        end
        if (last_idx) begin
          round_cnt <= round_cnt + 8'd1;
        end
      end
    end
  end

  // Packed view of the live weights, weight 0 in the low byte.
  for (genvar g = 0; g < N_W; g++) begin : g_pack
    assign weights_o[g*W_BITS +: W_BITS] = w_q[g];
  end

  assign upd_ack_o   = ack;
  assign load_done_o = done;
  assign round_cnt_o = round_cnt;
  assign err_o       = err;
  assign state_o     = state;

endmodule

// File: tb/tb_on_weight_store.sv
// Directed bench for on_weight_store: reset, updates, saturation, preload,
// load/update priority, abort, freeze, reset mid-load and round wrap.
module tb_on_weight_store;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        load_en;
  logic [3:0]  load_nib;
  logic        upd_valid;
  logic        upd_idx;
  logic [7:0]  upd_delta;
  logic        upd_ready;
  logic        upd_ack;
  logic        load_done;
  logic [15:0] weights;
  logic [7:0]  round_cnt;
  logic        err;
  logic [1:0]  state;

  int checks = 0;
  int passed = 0;

  on_weight_store dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .freeze_i    (freeze),
    .load_en_i   (load_en),
    .load_nib_i  (load_nib),
    .upd_valid_i (upd_valid),
    .upd_idx_i   (upd_idx),
    .upd_delta_i (upd_delta),
    .upd_ready_o (upd_ready),
    .upd_ack_o   (upd_ack),
    .load_done_o (load_done),
    .weights_o   (weights),
    .round_cnt_o (round_cnt),
    .err_o       (err),
    .state_o     (state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns so outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive four nibbles on consecutive cycles; returns in the COMMIT cycle.
  task automatic load4(input logic [3:0] n0, input logic [3:0] n1,
                       input logic [3:0] n2, input logic [3:0] n3);
    logic [3:0] nibs [4];
    nibs = '{n0, n1, n2, n3};
    load_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_nib = nibs[i];
      step();
    end
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    checks++; if (weights !== 16'h0201) $display("FAIL reset_weights: got %h want %h", weights, 16'h0201); else passed++;
    checks++; if (round_cnt !== 8'd0) $display("FAIL reset_round: got %0d want 0", round_cnt); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    checks++; if (upd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", upd_ready); else passed++;
    checks++; if (upd_ack !== 1'b0 || load_done !== 1'b0) $display("FAIL reset_pulses: got ack=%b done=%b want 0/0", upd_ack, load_done); else passed++;
    checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else passed++;
  endtask

  task automatic test_update();
    upd_valid = 1'b1; upd_idx = 1'b0; upd_delta = 8'hFD;
    step();
    upd_valid = 1'b0;
    checks++; if (weights !== 16'h0204) $display("FAIL upd0_weights: got %h want %h", weights, 16'h0204); else passed++;
    checks++; if (upd_ack !== 1'b1) $display("FAIL upd0_ack: got %b want 1", upd_ack); else passed++;
    step();
    checks++; if (upd_ack !== 1'b0) $display("FAIL upd0_ack_once: got %b want 0", upd_ack); else passed++;
    upd_valid = 1'b1; upd_idx = 1'b1; upd_delta = 8'h05;
    step();
    upd_valid = 1'b0;
    checks++; if (weights !== 16'hFD04) $display("FAIL upd1_weights: got %h want %h", weights, 16'hFD04); else passed++;
    checks++; if (round_cnt !== 8'd1) $display("FAIL upd1_round: got %0d want 1", round_cnt); else passed++;
    step();
  endtask

  task automatic test_saturation();
    load4(4'hE, 4'h7, 4'h0, 4'h0);
    step();
    checks++; if (weights !== 16'h007E) $display("FAIL sat_pos_load: got %h want %h", weights, 16'h007E); else passed++;
    upd_valid = 1'b1; upd_idx = 1'b0; upd_delta = 8'hFB;
    step();
    upd_valid = 1'b0;
    checks++; if (weights !== 16'h007F) $display("FAIL sat_pos: got %h want %h", weights, 16'h007F); else passed++;
    load4(4'h1, 4'h8, 4'h0, 4'h0);
    step();
    checks++; if (weights !== 16'h0081) $display("FAIL sat_neg_load: got %h want %h", weights, 16'h0081); else passed++;
    upd_valid = 1'b1; upd_idx = 1'b0; upd_delta = 8'h0A;
    step();
    upd_valid = 1'b0;
    checks++; if (weights !== 16'h0080) $display("FAIL sat_neg: got %h want %h", weights, 16'h0080); else passed++;
    checks++; if (round_cnt !== 8'd1) $display("FAIL sat_round: got %0d want 1", round_cnt); else passed++;
  endtask

  task automatic test_preload();
    // Update offered together with the first nibble: load must win.
    load_en = 1'b1; load_nib = 4'h5;
    upd_valid = 1'b1; upd_idx = 1'b0; upd_delta = 8'h01;
    #1;
    checks++; if (upd_ready !== 1'b0) $display("FAIL prio_ready: got %b want 0", upd_ready); else passed++;
    step();
    upd_valid = 1'b0;
    checks++; if (upd_ack !== 1'b0) $display("FAIL prio_ack: got %b want 0", upd_ack); else passed++;
    checks++; if (state !== 2'd1) $display("FAIL preload_state_load: got %0d want 1", state); else passed++;
    load_nib = 4'hA; step();
    load_nib = 4'h3; step();
    checks++; if (load_done !== 1'b0 || weights !== 16'h0080) $display("FAIL preload_early: got done=%b w=%h want 0/0080", load_done, weights); else passed++;
    load_nib = 4'hC; step();
    load_en = 1'b0;
    checks++; if (load_done !== 1'b1) $display("FAIL preload_done: got %b want 1", load_done); else passed++;
    checks++; if (weights !== 16'hC3A5) $display("FAIL preload_weights: got %h want %h", weights, 16'hC3A5); else passed++;
    checks++; if (state !== 2'd2) $display("FAIL preload_commit_state: got %0d want 2", state); else passed++;
    step();
    checks++; if (load_done !== 1'b0 || state !== 2'd0) $display("FAIL preload_after: got done=%b state=%0d want 0/0", load_done, state); else passed++;
  endtask

  task automatic test_back_to_back();
    upd_valid = 1'b1; upd_idx = 1'b1; upd_delta = 8'h01;
    step();
    checks++; if (weights !== 16'hC2A5) $display("FAIL b2b_first: got %h want %h", weights, 16'hC2A5); else passed++;
    step();
    upd_valid = 1'b0;
    checks++; if (weights !== 16'hC1A5) $display("FAIL b2b_second: got %h want %h", weights, 16'hC1A5); else passed++;
    checks++; if (round_cnt !== 8'd3) $display("FAIL b2b_round: got %0d want 3", round_cnt); else passed++;
    checks++; if (upd_ack !== 1'b1) $display("FAIL b2b_ack: got %b want 1", upd_ack); else passed++;
    step();
  endtask

  task automatic test_abort();
    checks++; if (err !== 1'b0) $display("FAIL abort_err_before: got %b want 0", err); else passed++;
    load_en = 1'b1;
    load_nib = 4'h1; step();
    load_nib = 4'h2; step();
    load_en = 1'b0;
    step();
    checks++; if (err !== 1'b1) $display("FAIL abort_err: got %b want 1", err); else passed++;
    checks++; if (weights !== 16'hC1A5) $display("FAIL abort_weights: got %h want %h", weights, 16'hC1A5); else passed++;
    checks++; if (state !== 2'd0 || load_done !== 1'b0) $display("FAIL abort_state: got state=%0d done=%b want 0/0", state, load_done); else passed++;
    step();
    checks++; if (err !== 1'b1) $display("FAIL abort_sticky: got %b want 1", err); else passed++;
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    upd_valid = 1'b1; upd_idx = 1'b0; upd_delta = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (upd_ready !== 1'b0) $display("FAIL freeze_ready_%0d: got %b want 0", i, upd_ready); else passed++;
      checks++; if (weights !== 16'hC1A5 || upd_ack !== 1'b0) $display("FAIL freeze_hold_%0d: got w=%h ack=%b want C1A5/0", i, weights, upd_ack); else passed++;
    end
    freeze = 1'b0;
    #1;
    checks++; if (upd_ready !== 1'b1) $display("FAIL unfreeze_ready: got %b want 1", upd_ready); else passed++;
    step();
    upd_valid = 1'b0;
    checks++; if (weights !== 16'hC1A4 || upd_ack !== 1'b1) $display("FAIL unfreeze_apply: got w=%h ack=%b want C1A4/1", weights, upd_ack); else passed++;
    step();
    checks++; if (weights !== 16'hC1A4 || upd_ack !== 1'b0) $display("FAIL unfreeze_once: got w=%h ack=%b want C1A4/0", weights, upd_ack); else passed++;
  endtask

  task automatic test_reset_mid_load();
    load_en = 1'b1;
    load_nib = 4'h1; step();
    load_nib = 4'h2; step();
    load_nib = 4'h3; step();
    rst = 1'b0;
    load_nib = 4'h4;
    step();
    checks++; if (weights !== 16'h0201) $display("FAIL midload_weights: got %h want %h", weights, 16'h0201); else passed++;
    checks++; if (state !== 2'd0) $display("FAIL midload_state: got %0d want 0", state); else passed++;
    checks++; if (err !== 1'b0 || round_cnt !== 8'd0 || load_done !== 1'b0) $display("FAIL midload_regs: got err=%b round=%0d done=%b want 0/0/0", err, round_cnt, load_done); else passed++;
    rst = 1'b1;
    load_en = 1'b0;
    step();
  endtask

  task automatic test_round_wrap();
    upd_valid = 1'b1; upd_idx = 1'b1; upd_delta = 8'h00;
    for (int i = 0; i < 255; i++) begin
      step();
    end
    checks++; if (round_cnt !== 8'd255) $display("FAIL wrap_255: got %0d want 255", round_cnt); else passed++;
    step();
    upd_valid = 1'b0;
    checks++; if (round_cnt !== 8'd0) $display("FAIL wrap_0: got %0d want 0", round_cnt); else passed++;
    checks++; if (weights !== 16'h0201) $display("FAIL wrap_weights: got %h want %h", weights, 16'h0201); else passed++;
  endtask

  initial begin
    rst       = 1'b0;
    freeze    = 1'b0;
    load_en   = 1'b0;
    load_nib  = 4'h0;
    upd_valid = 1'b0;
    upd_idx   = 1'b0;
    upd_delta = 8'h00;
    test_reset();
    test_update();
    test_saturation();
    test_preload();
    test_back_to_back();
    test_abort();
    test_freeze();
    test_reset_mid_load();
    test_round_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
